// File: rtl/chan_sched_pkg.sv
// Shared types and helpers for the channel dump scheduler.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package chan_sched_pkg;

    // Largest channel count the one-hot helper can produce; callers cast down to N_CH.
    localparam int MAX_CH = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_GRANT = 2'd2,
        S_NEXT  = 2'd3
    } sched_state_e;

    // Width of a binary channel index for n channels (n >= 2).
    function automatic int ch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_CH-1:0] onehot_from_idx(input logic [7:0] idx);
        logic [MAX_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/chan_pick.sv
// Combinational priority picker: first set pending bit at or after start_idx_i, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; any_o=0 and idx_o=0 when nothing is pending.
// Ports: pending_i (request bits), start_idx_i (search origin), idx_o (chosen channel), any_o (found).
module chan_pick
    import chan_sched_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int IDX_W = ch_idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  pending_i,
    input  logic [IDX_W-1:0] start_idx_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // N_CH is a power of two, so plain IDX_W-bit addition gives the modulo wrap.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = start_idx_i + IDX_W'(i);
            if (!any_o && pending_i[cand]) begin
                any_o = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/channel_dump_scheduler.sv
// Per-frame channel readout scheduler: latch requests, grant channels one at a time.
// Latency: ARM 1 cycle after frame tick, first grant 2 cycles after ARM; grants registered.
// Backpressure: each grant held until dwell expires and ack_i=1; frame ticks while busy are dropped (overrun_o).
// Ports: clk_i/resetn_i, enable_i, frame_len_i, dwell_i, ch_req_i, ack_i, inter_i (abort) in;
//        arm_o, dump_o, ch_sel_o, ch_idx_o, grant_valid_o, cycle_done_o, idle_o, overrun_o out.
// Build option: define CH_SCHED_ROUND_ROBIN_EN for a round-robin search origin (default fixed priority).
module channel_dump_scheduler
    import chan_sched_pkg::*;
#(
    parameter int N_CH    = 16,
    parameter int DWELL_W = 8,
    parameter int FRAME_W = 16
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    enable_i,
    input  logic [FRAME_W-1:0]      frame_len_i,
    input  logic [DWELL_W-1:0]      dwell_i,
    input  logic [N_CH-1:0]         ch_req_i,
    input  logic                    ack_i,
    input  logic                    inter_i,
    output logic                    arm_o,
    output logic                    dump_o,
    output logic [N_CH-1:0]         ch_sel_o,
    output logic [$clog2(N_CH)-1:0] ch_idx_o,
    output logic                    grant_valid_o,
    output logic                    cycle_done_o,
    output logic                    idle_o,
    output logic                    overrun_o
);

    localparam int CH_IDX_W = ch_idx_w(N_CH);

    sched_state_e        state_q, state_d;
    logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [FRAME_W-1:0]  frame_top_q, frame_top_d;
    logic [N_CH-1:0]     pending_q, pending_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [N_CH-1:0]     sel_q, sel_d;
    logic [CH_IDX_W-1:0] idx_q, idx_d;
    logic                gv_q, gv_d;
    logic                dump_q, dump_d;
    logic                done_q, done_d;

    logic [FRAME_W-1:0]  top_in;
    logic [FRAME_W-1:0]  eff_top;
    logic                tick;
    logic [CH_IDX_W-1:0] start_idx;
    logic [CH_IDX_W-1:0] pick_idx;
    logic                pick_any;

    // Frame counter: the period is sampled whenever the count sits at 0, so a new
    // frame_len_i only applies from the next wrap. A length of 0 behaves as 1.
    assign top_in  = (frame_len_i == '0) ? '0 : frame_len_i - FRAME_W'(1);
    assign eff_top = (frame_cnt_q == '0) ? top_in : frame_top_q;
    assign tick    = enable_i && (frame_cnt_q == eff_top);

    always_comb begin
        frame_top_d = eff_top;
        frame_cnt_d = frame_cnt_q + FRAME_W'(1);
        if (!enable_i || tick) begin
            frame_cnt_d = '0;
        end
    end

`ifdef CH_SCHED_ROUND_ROBIN_EN
    // Resets to all-ones so the first search after reset starts at channel 0.
    logic [CH_IDX_W-1:0] last_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            last_q <= '1;
        end else if (state_q == S_NEXT && pick_any && !inter_i) begin
            last_q <= pick_idx;
        end
    end

    assign start_idx = last_q + CH_IDX_W'(1);
`else
    assign start_idx = '0;
`endif

    chan_pick #(
        .N_CH  (N_CH),
        .IDX_W (CH_IDX_W)
    ) u_pick (
        .pending_i   (pending_q),
        .start_idx_i (start_idx),
        .idx_o       (pick_idx),
        .any_o       (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dwell_d   = dwell_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        gv_d      = gv_q;
        dump_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                pending_d = ch_req_i;
                state_d   = S_NEXT;
            end
            S_NEXT: begin
                if (!pick_any) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    sel_d   = N_CH'(onehot_from_idx(8'(pick_idx)));
                    idx_d   = pick_idx;
                    gv_d    = 1'b1;
                    dump_d  = 1'b1;
                    dwell_d = dwell_i;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                // ack_i only counts once the dwell counter has reached 0.
                if (dwell_q != '0) begin
                    dwell_d = dwell_q - DWELL_W'(1);
                end else if (ack_i) begin
                    pending_d[idx_q] = 1'b0;
                    sel_d            = '0;
                    idx_d            = '0;
                    gv_d             = 1'b0;
                    state_d          = S_NEXT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything else, including a same-cycle ack.
        if (inter_i && state_q != S_IDLE) begin
            pending_d = '0;
            dwell_d   = '0;
            sel_d     = '0;
            idx_d     = '0;
            gv_d      = 1'b0;
            dump_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            frame_top_q <= '0;
            pending_q   <= '0;
            dwell_q     <= '0;
            sel_q       <= '0;
            idx_q       <= '0;
            gv_q        <= 1'b0;
            dump_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            frame_top_q <= frame_top_d;
            pending_q   <= pending_d;
            dwell_q     <= dwell_d;
            sel_q       <= sel_d;
            idx_q       <= idx_d;
            gv_q        <= gv_d;
            dump_q      <= dump_d;
            done_q      <= done_d;
        end
    end

    assign arm_o         = (state_q == S_ARM);
    assign idle_o        = (state_q == S_IDLE);
    assign overrun_o     = tick && (state_q != S_IDLE);
    assign dump_o        = dump_q;
    assign cycle_done_o  = done_q;
    assign ch_sel_o      = sel_q;
    assign ch_idx_o      = idx_q;
    assign grant_valid_o = gv_q;

endmodule

// File: doc/channel_dump_scheduler.md
Name: channel_dump_scheduler

Overview:
Synchronous scheduler that sequences the channel readout for the multi-channel coder.
- Every frame it captures the channel request vector, then grants channels one at a time in priority order.
- Each grant is held for a programmable dwell and released only on downstream acknowledge.
- It emits arm and dump strobes, a one-hot select and an index, and completes a cycle per frame.

Parameters:
N_CH, 16, number of channels (power of 2, >=2)
DWELL_W, 8, width of dwell counter/config
FRAME_W, 16, width of frame-period counter/config

Ports:
clk_i  input  1  single clock, rising edge
resetn_i  input  1  asynchronous active-low reset
enable_i  input  1  allow new frames to start
frame_len_i  input  FRAME_W  frame period in cycles; 0 treated as 1
dwell_i  input  DWELL_W  minimum grant length in cycles after the first; 0 = ack-only
ch_req_i  input  N_CH  channel request vector, sampled on frame tick
ack_i  input  1  downstream done with the current channel
inter_i  input  1  abort the current frame
arm_o  output  1  1-cycle strobe, request vector latched
dump_o  output  1  1-cycle strobe on first cycle of each grant
ch_sel_o  output  N_CH  one-hot grant, all-zero when no grant
ch_idx_o  output  $clog2(N_CH)  binary index of granted channel, 0 when no grant
grant_valid_o  output  1  ch_sel_o/ch_idx_o valid
cycle_done_o  output  1  1-cycle strobe, frame finished or aborted
idle_o  output  1  FSM in IDLE
overrun_o  output  1  1-cycle strobe, frame tick lost while busy

Behaviour:
- Reset (async, resetn_i=0): FSM=IDLE, counters=0, pending=0, all outputs 0 except idle_o=1. Same result if reset is asserted mid-grant.
- Frame counter:
  - Counts 0..max(frame_len_i,1)-1 while enable_i=1; frame tick when the count equals the top value.
  - Held at 0 while enable_i=0.
  - A new frame_len_i value takes effect at the next wrap.
- FSM states: IDLE, ARM, GRANT, NEXT.
- IDLE: on frame tick, go to ARM.
- ARM (1 cycle):
  - pending <= ch_req_i; arm_o=1.
  - Next state is NEXT.
- NEXT (1 cycle, no grant output):
  - pending==0: cycle_done_o=1, go to IDLE.
  - Otherwise pick the channel via the priority picker, load the dwell counter with dwell_i, go to GRANT.
- GRANT:
  - ch_sel_o, ch_idx_o and grant_valid_o are registered and stable for the whole grant; dump_o=1 on the first cycle only.
  - The dwell counter decrements to 0 and saturates there.
  - The grant ends in the cycle where ack_i=1 and the dwell count is 0. On that edge: clear the pending bit, go to NEXT.
  - ack_i is ignored while the dwell count is nonzero.
  - Minimum grant length is dwell_i+1 cycles.
- inter_i=1 in ARM, NEXT or GRANT:
  - Next edge: pending<=0, grant dropped, cycle_done_o=1, go to IDLE.
  - inter_i has priority over ack_i in the same cycle. It is ignored in IDLE.
- Overrun: a frame tick in any state other than IDLE gives overrun_o=1 for 1 cycle. That frame is skipped, not queued.
- enable_i falling mid-frame: the current frame completes normally; no further ARM.
- Frame with ch_req_i=0: ARM then NEXT then cycle_done_o; no dump_o.
- ch_req_i changes after ARM have no effect until the next frame.

Optional Feature:
CH_SCHED_ROUND_ROBIN_EN
- Defined: the priority search starts at (last granted index + 1) mod N_CH, with the last granted index carried across frames. After reset the search starts at 0. An aborted grant still counts as granted.
- Undefined: fixed priority, lowest set index first, every pick.

Decomposition:
- Package chan_sched_pkg holds:
  - the FSM state enum (IDLE, ARM, GRANT, NEXT);
  - the CH_IDX_W localparam function of N_CH;
  - the onehot-from-index function.
- Sub-module chan_pick:
  - combinational picker with inputs pending[N_CH] and start_idx;
  - outputs idx and any.
  - start_idx is tied to 0 when round-robin is compiled out.

Test Plan:
- frame_len_i=10, dwell_i=0, ch_req_i=16'h0000 -> arm_o every 10 cycles, cycle_done_o 2 cycles after each arm, dump_o never.
- ch_req_i=16'h8105, dwell_i=2, ack_i tied 1 -> grants in order 0,2,8,15; each grant 3 cycles; dump_o once per grant; then cycle_done_o.
- ch_req_i=16'h0003, ack_i held 0 for 20 cycles, frame_len_i=8 -> ch_idx_o stays 0 with ch_sel_o=16'h0001; overrun_o pulses on each missed frame tick.
- Grant on channel 5, inter_i and ack_i high in the same cycle -> next cycle grant_valid_o=0, cycle_done_o=1, idle_o=1, and no grant to later channels.
- resetn_i asserted mid-GRANT -> all outputs 0 immediately (idle_o=1); after release, the first grant starts only after a full frame_len_i period.
- CH_SCHED_ROUND_ROBIN_EN defined, ch_req_i=16'h0011 for two frames, abort after the first grant -> frame 1 grants channel 0 only; frame 2 grants channel 4 first, then channel 0.
